// File: rtl/wb_sram16_pkg.sv
// Shared types and constants for the 16-bit async SRAM Wishbone controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package wb_sram16_pkg;

  // Width of the per-phase strobe counter; wait_cycles must fit (1..15).
  localparam int WAIT_CNT_W = 4;

  // Halfword select: HI phase carries bus bits [31:16] at even SRAM address.
  localparam logic PHASE_HI = 1'b0;
  localparam logic PHASE_LO = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HI_SETUP = 3'd1,
    HI_STB   = 3'd2,
    LO_SETUP = 3'd3,
    LO_STB   = 3'd4,
    ACK      = 3'd5
  } state_t;

endpackage

// File: rtl/wb_sram16_if.sv
// Wishbone classic slave bus (32-bit data, byte lanes, single-cycle ack).
// Latency: n/a (wiring only).
// Backpressure: master holds cyc/stb until ack; slave stalls by withholding ack.
// Ports: wb_adr_i/wb_dat_i/wb_sel_i/wb_we_i/wb_stb_i/wb_cyc_i master->slave,
//        wb_dat_o/wb_ack_o slave->master.
interface wb_sram16_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_sram16.sv
// Wishbone slave bridging 32-bit accesses onto a 16-bit async SRAM (two timed phases).
// Latency: full access ack at cycle 2W+3, single-phase write W+2, empty write 1.
// Backpressure: ack withheld until SRAM phases finish; one IDLE cycle between accesses.
// Ports: clk/reset; wb (Wishbone slave modport); sram_adr, sram_dat_o/sram_dat_i,
//        sram_dat_oe (pad drive), sram_ce_n/oe_n/we_n/ub_n/lb_n (active-low controls).
module wb_sram16
  import wb_sram16_pkg::*;
#(
  parameter int adr_width   = 18,
  parameter int wait_cycles = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_sram16_if.slave           wb,
  output logic [adr_width-1:0] sram_adr,
  output logic [15:0]          sram_dat_o,
  input  logic [15:0]          sram_dat_i,
  output logic                 sram_dat_oe,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n
);

  state_t                  state;
  logic [WAIT_CNT_W-1:0]   cnt;
  logic                    we_r;
  logic [3:0]              sel_r;
  logic [31:0]             dat_r;
  logic [adr_width-2:0]    word_r;

  // Request attributes: taken straight from the bus in IDLE, from the latched
  // copy once the access is under way.
  logic                    s_we;
  logic [3:0]              s_sel;
  logic [31:0]             s_dat;
  logic [adr_width-2:0]    s_word;
  logic                    req;
  logic                    stb_done;
  logic                    start;
  logic                    nxt_phase;

  // Address bits outside the word index are ignored by design.
  logic                    unused_adr;
  assign unused_adr = &{1'b0, wb.wb_adr_i[31:adr_width+1], wb.wb_adr_i[1:0]};

  function automatic logic hi_used(logic we, logic [3:0] sel);
    return !we || (|sel[3:2]);
  endfunction

  function automatic logic lo_used(logic we, logic [3:0] sel);
    return !we || (|sel[1:0]);
  endfunction

  // Reads always enable both byte lanes; writes enable only selected bytes.
  function automatic logic [1:0] lanes_n(logic we, logic [3:0] sel, logic phase);
    if (!we) return 2'b00;
    return (phase == PHASE_HI) ? ~sel[3:2] : ~sel[1:0];
  endfunction

  function automatic logic [15:0] half(logic [31:0] d, logic phase);
    return (phase == PHASE_HI) ? d[31:16] : d[15:0];
  endfunction

  assign req = wb.wb_cyc_i & wb.wb_stb_i;

  always_comb begin
    if (state == IDLE) begin
      s_we   = wb.wb_we_i;
      s_sel  = wb.wb_sel_i;
      s_dat  = wb.wb_dat_i;
      s_word = wb.wb_adr_i[adr_width:2];
    end else begin
      s_we   = we_r;
      s_sel  = sel_r;
      s_dat  = dat_r;
      s_word = word_r;
    end
    stb_done  = ((state == HI_STB) || (state == LO_STB)) && (cnt == '0);
    nxt_phase = ((state == IDLE) && hi_used(s_we, s_sel)) ? PHASE_HI : PHASE_LO;
    // A SETUP is entered from IDLE (unless the write has no lanes) or after the
    // HI strobe when the LO half is still needed and the master is still there.
    start = ((state == IDLE) && req && !(s_we && (s_sel == 4'b0000))) ||
            ((state == HI_STB) && stb_done && req && lo_used(we_r, sel_r));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      we_r        <= 1'b0;
      sel_r       <= '0;
      dat_r       <= '0;
      word_r      <= '0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      sram_adr    <= '0;
      sram_dat_o  <= '0;
      sram_dat_oe <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
      sram_ub_n   <= 1'b1;
      sram_lb_n   <= 1'b1;
    end else begin
      wb.wb_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_r   <= wb.wb_we_i;
            sel_r  <= wb.wb_sel_i;
            dat_r  <= wb.wb_dat_i;
            word_r <= wb.wb_adr_i[adr_width:2];
            if (wb.wb_we_i && (wb.wb_sel_i == 4'b0000)) begin
              state       <= ACK;
              wb.wb_ack_o <= 1'b1;
            end else begin
              state <= hi_used(wb.wb_we_i, wb.wb_sel_i) ? HI_SETUP : LO_SETUP;
            end
          end
        end
        HI_SETUP, LO_SETUP: begin
          state     <= (state == HI_SETUP) ? HI_STB : LO_STB;
          cnt       <= WAIT_CNT_W'(wait_cycles - 1);
          sram_we_n <= ~we_r;
          sram_oe_n <= we_r;
        end
        HI_STB, LO_STB: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Strobe always runs to completion; an abort is honoured only here.
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (!we_r) begin
              if (state == HI_STB) wb.wb_dat_o[31:16] <= sram_dat_i;
              else                 wb.wb_dat_o[15:0]  <= sram_dat_i;
            end
            if (!req) begin
              state <= IDLE;
            end else if ((state == HI_STB) && lo_used(we_r, sel_r)) begin
              state <= LO_SETUP;
            end else begin
              state       <= ACK;
              wb.wb_ack_o <= 1'b1;
            end
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase

      // Chip-level controls: set up a phase, or release the chip when a strobe ends
      // without a following phase. Address/data hold until the next phase edge.
      if (start) begin
        sram_ce_n              <= 1'b0;
        sram_adr               <= {s_word, nxt_phase};
        sram_dat_oe            <= s_we;
        {sram_ub_n, sram_lb_n} <= lanes_n(s_we, s_sel, nxt_phase);
        if (s_we) sram_dat_o <= half(s_dat, nxt_phase);
      end else if (stb_done) begin
        sram_ce_n   <= 1'b1;
        sram_dat_oe <= 1'b0;
        sram_ub_n   <= 1'b1;
        sram_lb_n   <= 1'b1;
      end
    end
  end

endmodule
